// File: rtl/markov_first_walk.sv
// markov_first_walk: walks a first-order Markov transition table and emits count-weighted notes; MARKOV_WALK_SEED_EN adds a seed port.
// States: IDLE wait start | SUM pass-1 total | DRAW scale LFSR to r | SELECT pass-2 pick | EMIT hold note | FINISH done pulse.
module markov_first_walk #(
  parameter int NOTE_W = 7,
  parameter int CNT_W  = 8,
  parameter int IDX_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef MARKOV_WALK_SEED_EN
  input  logic [15:0]               seed,
`endif
  input  logic                      start,
  input  logic [NOTE_W-1:0]         start_note,
  input  logic [15:0]               num_steps,
  output logic                      mem_rd_en,
  output logic [NOTE_W+IDX_W-1:0]   mem_addr,
  input  logic [NOTE_W+CNT_W-1:0]   mem_rdata,
  output logic [NOTE_W-1:0]         note_out,
  output logic                      note_valid,
  input  logic                      note_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      dead_end
);

  localparam int MAX_SUCC = 1 << IDX_W;
  localparam int TOT_W    = CNT_W + IDX_W;
  localparam int PROD_W   = 16 + TOT_W;
  localparam logic [15:0] LFSR_RST  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {IDLE, SUM, DRAW, SELECT, EMIT, FINISH} state_t;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [15:0]         steps_q, steps_d;
  logic [NOTE_W-1:0]   cur_note_q, cur_note_d;
  logic [NOTE_W-1:0]   chosen_q, chosen_d;
  logic [IDX_W:0]      rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]    rsp_idx_q;
  logic                rvalid_q;
  logic [TOT_W-1:0]    acc_q, acc_d;
  logic [TOT_W-1:0]    r_q, r_d;
  logic                dead_q, dead_d;

  logic [CNT_W-1:0]    rsp_cnt;
  logic [NOTE_W-1:0]   rsp_note;
  logic                rsp_last;
  logic [TOT_W-1:0]    acc_sum;
  logic [PROD_W-1:0]   prod;
  logic [15:0]         lfsr_step;

  assign rsp_cnt   = mem_rdata[CNT_W-1:0];
  assign rsp_note  = mem_rdata[NOTE_W+CNT_W-1:CNT_W];
  assign rsp_last  = (rsp_idx_q == IDX_W'(MAX_SUCC - 1));
  assign acc_sum   = acc_q + TOT_W'(rsp_cnt);
  assign prod      = PROD_W'(lfsr_q) * PROD_W'(acc_q);
  assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  assign mem_addr  = {cur_note_q, rd_idx_q[IDX_W-1:0]};
  assign note_out  = chosen_q;
  assign dead_end  = dead_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_RST;
      steps_q    <= '0;
      cur_note_q <= '0;
      chosen_q   <= '0;
      rd_idx_q   <= '0;
      rsp_idx_q  <= '0;
      rvalid_q   <= 1'b0;
      acc_q      <= '0;
      r_q        <= '0;
      dead_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      steps_q    <= steps_d;
      cur_note_q <= cur_note_d;
      chosen_q   <= chosen_d;
      rd_idx_q   <= rd_idx_d;
      rvalid_q   <= mem_rd_en;
      if (mem_rd_en) rsp_idx_q <= rd_idx_q[IDX_W-1:0];
      acc_q      <= acc_d;
      r_q        <= r_d;
      dead_q     <= dead_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_step;
    steps_d    = steps_q;
    cur_note_d = cur_note_q;
    chosen_d   = chosen_q;
    rd_idx_d   = rd_idx_q;
    acc_d      = acc_q;
    r_d        = r_q;
    dead_d     = dead_q;
    mem_rd_en  = 1'b0;
    note_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cur_note_d = start_note;
          steps_d    = num_steps;
          dead_d     = 1'b0;
          rd_idx_d   = '0;
          acc_d      = '0;
`ifdef MARKOV_WALK_SEED_EN
          lfsr_d     = (seed == 16'h0000) ? LFSR_RST : seed;
`endif
          state_d    = (num_steps == 16'h0000) ? FINISH : SUM;
        end
      end
      SUM: begin
        busy      = 1'b1;
        mem_rd_en = ~rd_idx_q[IDX_W];
        if (mem_rd_en) rd_idx_d = rd_idx_q + (IDX_W+1)'(1);
        // the read issued in the stopping cycle lands in DRAW and is ignored there
        if (rvalid_q) begin
          if (rsp_cnt == '0) begin
            if (acc_q == '0) begin
              dead_d  = 1'b1;
              state_d = FINISH;
            end else begin
              state_d = DRAW;
            end
          end else begin
            acc_d = acc_sum;
            if (rsp_last) state_d = DRAW;
          end
        end
      end
      DRAW: begin
        busy     = 1'b1;
        r_d      = TOT_W'(prod >> 16);
        acc_d    = '0;
        rd_idx_d = '0;
        state_d  = SELECT;
      end
      SELECT: begin
        busy      = 1'b1;
        mem_rd_en = ~rd_idx_q[IDX_W];
        if (mem_rd_en) rd_idx_d = rd_idx_q + (IDX_W+1)'(1);
        if (rvalid_q) begin
          acc_d = acc_sum;
          if ((acc_sum > r_q) || rsp_last) begin
            chosen_d = rsp_note;
            state_d  = EMIT;
          end
        end
      end
      EMIT: begin
        busy       = 1'b1;
        note_valid = 1'b1;
        if (note_ready) begin
          cur_note_d = chosen_q;
          steps_d    = steps_q - 16'd1;
          rd_idx_d   = '0;
          acc_d      = '0;
          state_d    = (steps_q == 16'd1) ? FINISH : SUM;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_markov_first_walk.sv
// Bench for markov_first_walk: a cycle-level model built from the per-step latency rules and a free-running LFSR model.
module tb_markov_first_walk;
  localparam int NOTE_W = 7;
  localparam int CNT_W  = 8;
  localparam int IDX_W  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  start_note = '0;
  logic [15:0] num_steps = '0;
  logic        mem_rd_en;
  logic [10:0] mem_addr;
  logic [14:0] mem_rdata = '0;
  logic [6:0]  note_out;
  logic        note_valid;
  logic        note_ready = 1'b1;
  logic        busy, done, dead_end;
`ifdef MARKOV_WALK_SEED_EN
  logic [15:0] seed = 16'h0000;
`endif

  markov_first_walk #(.NOTE_W(NOTE_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
`ifdef MARKOV_WALK_SEED_EN
    .seed(seed),
`endif
    .start(start), .start_note(start_note), .num_steps(num_steps),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .note_out(note_out), .note_valid(note_valid), .note_ready(note_ready),
    .busy(busy), .done(done), .dead_end(dead_end)
  );

  always #5 clk = ~clk;

  logic [14:0] tbl [0:2047];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= tbl[mem_addr];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction
  function automatic int cnt_of(input int note, input int i);
    logic [14:0] e;
    e = tbl[note*16 + i];
    return int'(e[7:0]);
  endfunction
  function automatic int note_of(input int note, input int i);
    logic [14:0] e;
    e = tbl[note*16 + i];
    return int'(e[14:8]);
  endfunction
  function automatic int list_len(input int note);
    for (int i = 0; i < 16; i++) if (cnt_of(note, i) == 0) return i;
    return 16;
  endfunction
  function automatic int list_total(input int note);
    int t = 0;
    for (int i = 0; i < list_len(note); i++) t += cnt_of(note, i);
    return t;
  endfunction
  function automatic int pick(input int note, input int r);
    int acc = 0;
    for (int i = 0; i < 16; i++) begin
      if (acc + cnt_of(note, i) > r) return i;
      acc += cnt_of(note, i);
    end
    return 15;
  endfunction

  // model state, written only by the compare process
  logic [15:0] m_lfsr, m_lfsr_nx;
  bit  m_walk = 0, m_emitting = 0, m_dead = 0;
  int  m_steps, m_cur, m_note;
  int  m_draw_cyc = -1, m_emit_cyc = -1, m_done_cyc = -10, m_dead_cyc = -1, m_busy_from = 0;
  int  got[$];
  int  r_seen[4];
  int  rd_cnt = 0, done_cnt = 0, valid_cnt = 0;

  task automatic begin_step(input int s);
    int len, tot;
    len = list_len(m_cur);
    tot = list_total(m_cur);
    m_dead_cyc = -1;
    m_draw_cyc = -1;
    if (tot == 0) begin
      m_dead_cyc = s + 2;
      m_done_cyc = s + 2;
    end else begin
      m_draw_cyc = s + ((len == 16) ? 17 : len + 2);
    end
  endtask

  always @(negedge clk) begin : cmp
    int tot, r, idx;
    bit exp_valid, exp_busy, accept;
    if (!reset) begin
      check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_note_out", 32'(note_out), 32'd0);
      check("rst_note_valid", 32'(note_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dead_end", 32'(dead_end), 32'd0);
      m_walk = 0; m_emitting = 0; m_dead = 0;
      m_draw_cyc = -1; m_done_cyc = -10; m_dead_cyc = -1;
      cyc = 0;
      m_lfsr = 16'hACE1;
      m_lfsr_nx = lfsr_adv(16'hACE1);
    end else begin
      cyc++;
      m_lfsr = m_lfsr_nx;
      if (m_walk && cyc == m_dead_cyc) m_dead = 1;
      if (m_walk && cyc == m_draw_cyc) begin
        tot = list_total(m_cur);
        r = int'((32'(m_lfsr) * 32'(tot)) >> 16);
        idx = pick(m_cur, r);
        m_note = note_of(m_cur, idx);
        m_emit_cyc = cyc + idx + 3;
        m_emitting = 1;
        if (tot == 4) r_seen[r]++;
      end
      exp_valid = m_emitting && (cyc >= m_emit_cyc);
      exp_busy = m_walk && (cyc >= m_busy_from) && !(m_done_cyc >= 0 && cyc >= m_done_cyc);
      check("note_valid", 32'(note_valid), 32'(exp_valid));
      check("done", 32'(done), 32'(m_walk && cyc == m_done_cyc));
      check("busy", 32'(busy), 32'(exp_busy));
      check("dead_end", 32'(dead_end), 32'(m_dead));
      if (exp_valid) begin
        check("note_out", 32'(note_out), 32'(m_note));
        check("rd_during_emit", 32'(mem_rd_en), 32'd0);
      end
      if (!m_walk) check("rd_while_idle", 32'(mem_rd_en), 32'd0);
      if (mem_rd_en) rd_cnt++;
      if (done) done_cnt++;
      if (note_valid) valid_cnt++;
      if (exp_valid && note_ready) begin
        got.push_back(m_note);
        m_cur = m_note;
        m_emitting = 0;
        m_steps--;
        if (m_steps == 0) m_done_cyc = cyc + 1;
        else begin_step(cyc + 1);
      end
      accept = !m_walk && start;
      m_lfsr_nx = lfsr_adv(m_lfsr);
      if (accept) begin
        m_dead = 0;
        m_walk = 1;
        m_busy_from = cyc + 1;
        m_steps = int'(num_steps);
        m_cur = int'(start_note);
        m_done_cyc = -10;
        m_emitting = 0;
`ifdef MARKOV_WALK_SEED_EN
        m_lfsr_nx = (seed == 16'h0000) ? 16'hACE1 : seed;
`endif
        if (num_steps == 16'd0) m_done_cyc = cyc + 1;
        else begin_step(cyc + 1);
      end else if (m_walk && cyc == m_done_cyc) begin
        m_walk = 0;
      end
    end
  end

  task automatic do_start(input int note, input int steps);
    @(posedge clk); #1;
    start = 1'b1; start_note = 7'(note); num_steps = 16'(steps);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic set_ent(input int note, input int i, input int nx, input int cnt);
    tbl[note*16 + i] = {7'(nx), 8'(cnt)};
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < 2048; i++) tbl[i] = '0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, n1;
    bit seen16 [16];
    int run_a[$];
    clear_tbl();
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;

    // single successor chain 5 -> 7 -> 5
    set_ent(5, 0, 7, 3);
    set_ent(7, 0, 5, 1);
    got.delete();
    do_start(5, 4);
    wait_done(300, "t1_done_seen");
    check("t1_count", 32'(got.size()), 32'd4);
    check("t1_n0", 32'(got.size() > 0 ? got[0] : 99), 32'd7);
    check("t1_n1", 32'(got.size() > 1 ? got[1] : 99), 32'd5);
    check("t1_n2", 32'(got.size() > 2 ? got[2] : 99), 32'd7);
    check("t1_n3", 32'(got.size() > 3 ? got[3] : 99), 32'd5);
    check("t1_dead_end", 32'(dead_end), 32'd0);

    // dead end at note 9, then cleared by the next walk
    snap = valid_cnt;
    do_start(9, 3);
    wait_done(50, "t2_done_seen");
    check("t2_no_valid", 32'(valid_cnt - snap), 32'd0);
    check("t2_dead_end", 32'(dead_end), 32'd1);
    do_start(5, 1);
    @(negedge clk);
    check("t2_dead_cleared", 32'(dead_end), 32'd0);
    wait_done(100, "t2b_done_seen");

    // weighting 1:3 between notes 0 and 1
    set_ent(0, 0, 0, 1); set_ent(0, 1, 1, 3);
    set_ent(1, 0, 0, 1); set_ent(1, 1, 1, 3);
    got.delete();
    for (int i = 0; i < 4; i++) r_seen[i] = 0;
    do_start(0, 1000);
    wait_done(20000, "t3_done_seen");
    check("t3_count", 32'(got.size()), 32'd1000);
    n1 = 0;
    foreach (got[i]) if (got[i] == 1) n1++;
    check("t3_ones_700_800", 32'(n1 >= 700 && n1 <= 800), 32'd1);
    for (int i = 0; i < 4; i++) check("t3_r_covered", 32'(r_seen[i] > 0), 32'd1);

    // full 16-slot list with no terminator
    for (int i = 0; i < 16; i++) begin
      set_ent(2, i, 20 + i, 1);
      set_ent(20 + i, 0, 2, 1);
    end
    got.delete();
    do_start(2, 2000);
    wait_done(70000, "t4_done_seen");
    check("t4_count", 32'(got.size()), 32'd2000);
    for (int i = 0; i < 16; i++) seen16[i] = 0;
    foreach (got[i]) if (got[i] >= 20 && got[i] < 36) seen16[got[i] - 20] = 1;
    for (int i = 0; i < 16; i++) check("t4_succ_seen", 32'(seen16[i]), 32'd1);

    // backpressure on the first emitted note (7)
    got.delete();
    note_ready = 1'b0;
    do_start(5, 2);
    for (int i = 0; i < 200 && !note_valid; i++) @(negedge clk);
    check("t5_valid_reached", 32'(note_valid), 32'd1);
    snap = rd_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t5_hold_valid", 32'(note_valid), 32'd1);
      check("t5_hold_note", 32'(note_out), 32'd7);
    end
    check("t5_no_reads", 32'(rd_cnt - snap), 32'd0);
    @(posedge clk); #1 note_ready = 1'b1;
    @(posedge clk); #1 note_ready = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_one_transfer", 32'(got.size()), 32'd1);
    note_ready = 1'b1;
    wait_done(100, "t5_done_seen");
    check("t5_total", 32'(got.size()), 32'd2);

    // num_steps == 0
    snap = rd_cnt;
    do_start(5, 0);
    @(negedge clk);
    check("t6_zero_done", 32'(done), 32'd1);
    check("t6_zero_no_reads", 32'(rd_cnt - snap), 32'd0);

    // start while busy is ignored
    got.delete();
    do_start(5, 2);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; start_note = 7'd9; num_steps = 16'd0;
    @(posedge clk); #1 start = 1'b0;
    wait_done(100, "t7_done_seen");
    check("t7_count", 32'(got.size()), 32'd2);
    check("t7_n0", 32'(got.size() > 0 ? got[0] : 99), 32'd7);
    check("t7_n1", 32'(got.size() > 1 ? got[1] : 99), 32'd5);
    check("t7_dead_end", 32'(dead_end), 32'd0);

`ifdef MARKOV_WALK_SEED_EN
    seed = 16'h1234;
    got.delete();
    do_start(2, 32);
    wait_done(3000, "t8a_done_seen");
    run_a = got;
    repeat (7) @(negedge clk);
    got.delete();
    do_start(2, 32);
    wait_done(3000, "t8b_done_seen");
    check("t8_len", 32'(got.size()), 32'd32);
    for (int i = 0; i < 32; i++)
      check("t8_same_seq", 32'(i < got.size() ? got[i] : -1), 32'(i < run_a.size() ? run_a[i] : -2));
`endif

    // reset during SELECT: SUM takes 17 cycles, DRAW 1, SELECT starts 18 cycles after the first SUM cycle
    do_start(2, 5);
    repeat (19) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("t9_rd_en", 32'(mem_rd_en), 32'd0);
    check("t9_addr", 32'(mem_addr), 32'd0);
    check("t9_note_out", 32'(note_out), 32'd0);
    check("t9_valid", 32'(note_valid), 32'd0);
    check("t9_busy", 32'(busy), 32'd0);
    check("t9_done", 32'(done), 32'd0);
    check("t9_dead", 32'(dead_end), 32'd0);
    snap = done_cnt;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    repeat (30) @(negedge clk);
    check("t9_no_done_pulse", 32'(done_cnt - snap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
